// File: rtl/nanorv32_urom_seq.sv
// -----------------------------------------------------------------------------
// nanorv32_urom_seq
//
// Purpose
//   Reads the nanorv32 micro-ROM and hands its words to decode. A reset,
//   interrupt-entry or interrupt-exit request starts a walk through the ROM at
//   the sequence base address. Each word is offered to decode on a valid/ready
//   handshake. The walk stops at the END marker word. The END word is consumed
//   and never issued. The walk is also aborted after MAX_LEN issued words, or
//   when the address would wrap.
//
// Ports
//   i_clk            core clock
//   i_rst            synchronous, active-high reset
//   i_req_reset      level request: reset sequence (highest priority)
//   i_req_irq_entry  level request: interrupt-entry sequence
//   i_req_irq_exit   level request: interrupt-exit sequence (lowest priority)
//   o_urom_addr      address to the asynchronous micro-ROM
//   i_urom_dout      micro-ROM data for o_urom_addr, same cycle
//   o_instr_valid    o_instr holds a word for decode
//   o_instr          sequenced word
//   i_instr_ready    decode accepts o_instr this cycle
//   o_busy           a sequence is in progress
//   o_done           one-cycle pulse when a sequence finishes
//   o_err            one-cycle pulse together with o_done on an abort
//   o_dbg_state      current FSM state, for debug and checkers
//   o_dbg_cnt        words issued so far in the current sequence
//
// Handshake
//   A word transfers on a rising edge where o_instr_valid and i_instr_ready are
//   both high. Once o_instr_valid is raised, it and o_instr stay unchanged until
//   that transfer happens. i_instr_ready has no effect while o_instr_valid is low.
// -----------------------------------------------------------------------------
module nanorv32_urom_seq #(
   parameter int unsigned       ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] BASE_RESET  = ADDR_W'(0),
   parameter logic [ADDR_W-1:0] BASE_IENTRY = ADDR_W'(2),
   parameter logic [ADDR_W-1:0] BASE_IEXIT  = ADDR_W'(4),
   parameter logic [31:0]       END_WORD    = 32'h0000_0001,
   parameter int unsigned       MAX_LEN     = 16,
   parameter bit                AUTO_BOOT   = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_reset,
   input  logic              i_req_irq_entry,
   input  logic              i_req_irq_exit,
   output logic [ADDR_W-1:0] o_urom_addr,
   input  logic [31:0]       i_urom_dout,
   output logic              o_instr_valid,
   output logic [31:0]       o_instr,
   input  logic              i_instr_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [1:0]        o_dbg_state,
   output logic [$clog2(MAX_LEN+1)-1:0] o_dbg_cnt
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int unsigned       CNT_W     = $clog2(MAX_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_instr;
   logic              r_err;

   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [31:0]       w_instr_nxt;
   logic              w_err_nxt;

   logic              w_any_req;
   logic [ADDR_W-1:0] w_base;
   logic              w_is_end;
   logic              w_accept;
   logic              w_abort;

   // ---------------------------------------------------------------------------
   // Request arbitration: reset > irq entry > irq exit
   // ---------------------------------------------------------------------------
   always_comb begin
      w_any_req = i_req_reset | i_req_irq_entry | i_req_irq_exit;
      if (i_req_reset) begin
         w_base = BASE_RESET;
      end else if (i_req_irq_entry) begin
         w_base = BASE_IENTRY;
      end else begin
         w_base = BASE_IEXIT;
      end
   end

   assign w_is_end = (i_urom_dout == END_WORD);
   assign w_accept = (r_state == ST_ISSUE) && i_instr_ready;

   // The word being accepted is the last allowed one. This happens either
   // because the count limit is reached, or because this is the top address
   // and the next address would wrap to zero.
   assign w_abort  = (r_cnt == CNT_LAST) || (r_addr == ADDR_LAST);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_instr_nxt = r_instr;
      w_err_nxt   = r_err;

      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_addr_nxt  = w_base;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_FETCH;
            end
         end

         ST_FETCH: begin
            // The ROM is combinational, so the word at r_addr is available now.
            if (w_is_end) begin
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_DONE;
            end else begin
               w_instr_nxt = i_urom_dout;
               w_state_nxt = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (w_accept) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (w_abort) begin
                  // On an abort the address is not advanced. At the top
                  // address, advancing would wrap it.
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_addr_nxt  = r_addr + ADDR_W'(1);
                  w_state_nxt = ST_FETCH;
               end
            end
         end

         ST_DONE: begin
            // Requests are not sampled here. A request still held, or raised
            // again, is taken in the following IDLE cycle.
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // With auto-boot, reset leaves the sequencer already fetching the
         // reset sequence. Any sequence in flight is dropped without a done.
         r_state <= AUTO_BOOT ? ST_FETCH : ST_IDLE;
         r_addr  <= AUTO_BOOT ? BASE_RESET : ADDR_W'(0);
         r_cnt   <= '0;
         r_instr <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_instr <= w_instr_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_urom_addr   = r_addr;
   assign o_instr       = r_instr;
   assign o_instr_valid = (r_state == ST_ISSUE);
   assign o_done        = (r_state == ST_DONE);
   assign o_err         = (r_state == ST_DONE) && r_err;

   // Busy reads low while reset is held. After reset is released, busy
   // follows the state register, so with auto-boot it rises at once.
   assign o_busy        = !i_rst && (r_state != ST_IDLE);

   assign o_dbg_state   = r_state;
   assign o_dbg_cnt     = r_cnt;

endmodule

// File: tb/tb_nanorv32_urom_seq.sv
module tb_nanorv32_urom_seq;

  localparam int          ADDR_W    = 8;
  localparam logic [7:0]  B_RESET   = 8'd0;
  localparam logic [7:0]  B_IENTRY  = 8'd2;
  localparam logic [7:0]  B_IEXIT   = 8'd4;
  localparam logic [31:0] END_W     = 32'h0000_0001;
  localparam int          MAX_LEN   = 16;
  localparam bit          AUTO_BOOT = 1'b1;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_reset, req_irq_entry, req_irq_exit;
  logic [7:0]  urom_addr;
  logic [31:0] urom_dout;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        busy, done, err;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_cnt;

  logic [31:0] rom [0:255];

  always #5 clk = ~clk;

  assign urom_dout = rom[urom_addr];

  nanorv32_urom_seq #(
    .ADDR_W(ADDR_W), .BASE_RESET(B_RESET), .BASE_IENTRY(B_IENTRY),
    .BASE_IEXIT(B_IEXIT), .END_WORD(END_W), .MAX_LEN(MAX_LEN),
    .AUTO_BOOT(AUTO_BOOT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_reset(req_reset), .i_req_irq_entry(req_irq_entry),
    .i_req_irq_exit(req_irq_exit),
    .o_urom_addr(urom_addr), .i_urom_dout(urom_dout),
    .o_instr_valid(instr_valid), .o_instr(instr), .i_instr_ready(instr_ready),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sequence is the list of words the ROM holds from its base address.
  // The list stops before the END word, or is cut after MAX_LEN words or at
  // the top address (abort). Each word takes one lookup cycle, then one or
  // more offer cycles. After the list, an END-terminated sequence spends one
  // more lookup cycle; then a done cycle follows.
  logic [31:0] exp_q[$];
  bit          m_abort, m_on, m_offer, m_done_now, m_done_err, m_reset, m_init;
  int          m_i;
  logic [7:0]  m_base;

  task automatic m_start(input logic [7:0] base);
    exp_q.delete();
    m_abort = 1'b0;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] a;
      a = base + 8'(k);
      if (rom[a] == END_W) break;
      exp_q.push_back(rom[a]);
      if (exp_q.size() == MAX_LEN || a == 8'hFF) begin
        m_abort = 1'b1;
        break;
      end
    end
    m_base  = base;
    m_i     = 0;
    m_on    = 1'b1;
    m_offer = 1'b0;
  endtask

  initial begin
    m_on = 0; m_offer = 0; m_done_now = 0; m_done_err = 0; m_reset = 0; m_init = 0;
    m_i = 0; m_base = 0; m_abort = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_init     = 1'b1;
      m_reset    = 1'b1;
      m_done_now = 1'b0;
      if (AUTO_BOOT) m_start(B_RESET);
      else m_on = 1'b0;
    end else if (m_init) begin
      m_reset = 1'b0;
      if (m_done_now) begin
        m_done_now = 1'b0;
      end else if (!m_on) begin
        if (req_reset)          m_start(B_RESET);
        else if (req_irq_entry) m_start(B_IENTRY);
        else if (req_irq_exit)  m_start(B_IEXIT);
      end else if (!m_offer) begin
        if (m_i == exp_q.size()) begin
          m_on = 1'b0; m_done_now = 1'b1; m_done_err = 1'b0;
        end else begin
          m_offer = 1'b1;
        end
      end else if (instr_ready) begin
        m_i++;
        m_offer = 1'b0;
        if (m_abort && m_i == exp_q.size()) begin
          m_on = 1'b0; m_done_now = 1'b1; m_done_err = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy",  32'(busy),        32'(!rst && (m_on || m_done_now)));
      chk("done",  32'(done),        32'(m_done_now));
      chk("err",   32'(err),         32'(m_done_now && m_done_err));
      chk("valid", 32'(instr_valid), 32'(m_on && m_offer));
      if (m_on && m_offer) chk("instr", instr, exp_q[m_i]);
      if (m_on) chk("addr", 32'(urom_addr), 32'(m_base + 8'(m_i)));
      if (m_reset) begin
        chk("rst_instr", instr, 32'h0);
        chk("rst_addr",  32'(urom_addr), 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rom_default();
    for (int a = 0; a < 256; a++) rom[a] = 32'hA500_0000 | 32'(a);
    rom[0] = 32'h0010009; rom[1] = END_W;
    rom[2] = 32'h0020009; rom[3] = END_W;
    rom[4] = 32'h0030009; rom[5] = END_W;
  endtask

  task automatic wait_valid(input int budget, output logic [31:0] w);
    bit ok;
    ok = 1'b0;
    w  = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (instr_valid) begin ok = 1'b1; w = instr; break; end
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget, output bit e);
    bit ok;
    ok = 1'b0;
    e  = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; e = err; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!m_on && !m_done_now) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    bit          e;
    int          n_acc;

    rom_default();
    rst = 1'b1; req_reset = 0; req_irq_entry = 0; req_irq_exit = 0; instr_ready = 1'b1;

    // Auto boot after reset: one word, then done without error.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("boot_addr0", 32'(urom_addr), 32'd0);
    chk("boot_busy",  32'(busy), 32'd1);
    @(negedge clk);
    chk("boot_valid", 32'(instr_valid), 32'd1);
    chk("boot_instr", instr, 32'h0010009);
    chk("boot_addr1", 32'(urom_addr), 32'd0);
    @(negedge clk);
    chk("boot_addr2", 32'(urom_addr), 32'd1);
    @(negedge clk);
    chk("boot_done", 32'(done), 32'd1);
    chk("boot_err",  32'(err),  32'd0);
    @(negedge clk);
    chk("boot_idle", 32'(busy), 32'd0);

    // Interrupt-entry request: word valid two cycles after it is seen in IDLE.
    tick(); req_irq_entry = 1'b1;
    tick(); req_irq_entry = 1'b0;
    @(negedge clk);
    chk("ient_fetch_addr", 32'(urom_addr), 32'd2);
    chk("ient_fetch_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("ient_instr", instr, 32'h0020009);
    chk("ient_valid", 32'(instr_valid), 32'd1);
    @(negedge clk);
    chk("ient_addr3", 32'(urom_addr), 32'd3);
    @(negedge clk);
    chk("ient_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("ient_busy0", 32'(busy), 32'd0);

    // Reset and irq-exit requests together: reset sequence first, exit next.
    tick(); req_reset = 1'b1; req_irq_exit = 1'b1;
    tick(); req_reset = 1'b0;
    wait_valid(20, w);
    chk("prio_first", w, 32'h0010009);
    wait_done(20, e);
    wait_valid(20, w);
    chk("prio_second", w, 32'h0030009);
    tick(); req_irq_exit = 1'b0;
    wait_done(20, e);
    wait_idle(20);

    // Back-pressure: ready low for five cycles holds the word and address.
    instr_ready = 1'b0;
    tick(); req_irq_entry = 1'b1;
    tick(); req_irq_entry = 1'b0;
    wait_valid(20, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, 32'h0020009);
      chk("hold_addr",  32'(urom_addr), 32'd2);
    end
    tick(); instr_ready = 1'b1;
    wait_done(20, e);
    chk("hold_err", 32'(e), 32'd0);
    wait_idle(20);

    // No END marker from base 0: MAX_LEN words, then an aborted done.
    tick();
    for (int a = 0; a < 48; a++) rom[a] = 32'h1000_0000 | 32'(a);
    req_reset = 1'b1;
    tick(); req_reset = 1'b0;
    n_acc = 0;
    e = 1'b0;
    begin : maxlen_loop
      for (int c = 0; c < 300; c++) begin
        instr_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (instr_valid && instr_ready) n_acc++;
        if (done) begin e = err; disable maxlen_loop; end
        tick();
      end
      chk("maxlen_timeout", 32'd0, 32'd1);
    end
    chk("maxlen_count", 32'(n_acc), 32'd16);
    chk("maxlen_err",   32'(e), 32'd1);
    instr_ready = 1'b1;
    wait_idle(20);
    tick();
    rom_default();

    // Reset during ISSUE of the irq-exit sequence.
    instr_ready = 1'b0;
    req_irq_exit = 1'b1;
    tick(); req_irq_exit = 1'b0;
    wait_valid(20, w);
    chk("rmid_word", w, 32'h0030009);
    tick(); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rmid_valid", 32'(instr_valid), 32'd0);
    chk("rmid_instr", instr, 32'd0);
    chk("rmid_done",  32'(done), 32'd0);
    chk("rmid_err",   32'(err), 32'd0);
    chk("rmid_addr",  32'(urom_addr), 32'd0);
    chk("rmid_busy",  32'(busy), 32'd0);
    tick(); rst = 1'b0; instr_ready = 1'b1;
    wait_done(20, e);
    wait_idle(20);

    // Randomised rounds: new ROM image each round, random requests/ready/reset.
    for (int r = 0; r < 20; r++) begin
      req_reset = 0; req_irq_entry = 0; req_irq_exit = 0; rst = 0; instr_ready = 1;
      wait_idle(100);
      tick();
      for (int a = 0; a < 64; a++)
        rom[a] = ($urandom_range(0, 4) == 0) ? END_W : $urandom;
      for (int c = 0; c < 150; c++) begin
        tick();
        req_reset     = ($urandom_range(0, 9) == 0);
        req_irq_entry = ($urandom_range(0, 7) == 0);
        req_irq_exit  = ($urandom_range(0, 7) == 0);
        instr_ready   = ($urandom_range(0, 3) != 0);
        rst           = ($urandom_range(0, 63) == 0);
      end
    end
    tick();
    req_reset = 0; req_irq_entry = 0; req_irq_exit = 0; rst = 0; instr_ready = 1;
    wait_idle(100);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
